// File: rtl/assist_seq_pkg.sv
// assist_seq_pkg -- shared types and constants for the assist sequencer.
//   state_t       : sequencer FSM states (IDLE / WAIT / UPDATE)
//   TORQUE_MIN    : minimum meaningful crank torque reading
//   DD_LAT_DEF    : default desired-drive pipeline depth (clocks)
//   SLEW_STEP_DEF : default maximum target_curr change per update
package assist_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [11:0] TORQUE_MIN    = 12'h380;
    localparam int          DD_LAT_DEF    = 3;
    localparam logic [11:0] SLEW_STEP_DEF = 12'h040;

endpackage

// File: rtl/assist_seq_if.sv
// assist_seq_if -- sensor-in / desired-drive / motor-command bundle.
//   sample_rdy, avg_torque, cadence, incline, scale, not_pedaling : sensor side
//   dd_* (5 operands) and dd_target_curr                          : datapath side
//   target_curr, curr_vld, busy, ovr_cnt                          : command side
// Modports: slave = sequencer, master = environment (sensors + datapath).
interface assist_seq_if;
    logic        sample_rdy;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic        not_pedaling;

    logic [11:0] dd_avg_torque;
    logic [4:0]  dd_cadence;
    logic [12:0] dd_incline;
    logic [2:0]  dd_scale;
    logic        dd_not_pedaling;
    logic [11:0] dd_target_curr;

    logic [11:0] target_curr;
    logic        curr_vld;
    logic        busy;
    logic [7:0]  ovr_cnt;

    modport slave (
        input  sample_rdy, avg_torque, cadence, incline, scale, not_pedaling,
        input  dd_target_curr,
        output dd_avg_torque, dd_cadence, dd_incline, dd_scale, dd_not_pedaling,
        output target_curr, curr_vld, busy, ovr_cnt
    );

    modport master (
        output sample_rdy, avg_torque, cadence, incline, scale, not_pedaling,
        output dd_target_curr,
        input  dd_avg_torque, dd_cadence, dd_incline, dd_scale, dd_not_pedaling,
        input  target_curr, curr_vld, busy, ovr_cnt
    );
endinterface

// File: rtl/assist_seq_curr_slew.sv
// curr_slew -- combinational slew limiter for the motor current command.
//   cur : current target_curr
//   tgt : freshly captured datapath result
//   nxt : cur moved toward tgt by at most STEP, never past tgt
// Only instantiated when SLEW_LIMIT_EN is defined.
module curr_slew
    import assist_seq_pkg::*;
#(
    parameter logic [11:0] STEP = SLEW_STEP_DEF
) (
    input  logic [11:0] cur,
    input  logic [11:0] tgt,
    output logic [11:0] nxt
);
    logic [11:0] diff;

    // Stepping only when the gap exceeds STEP means cur+STEP < tgt <= FFF and
    // cur-STEP > tgt >= 0, so neither direction can wrap.
    always_comb begin
        nxt  = tgt;
        diff = '0;
        if (tgt > cur) begin
            diff = tgt - cur;
            if (diff > STEP) nxt = cur + STEP;
        end else begin
            diff = cur - tgt;
            if (diff > STEP) nxt = cur - STEP;
        end
    end
endmodule

// File: rtl/assist_seq.sv
// assist_seq -- sequences sensor samples through the desired-drive datapath
// and issues the motor current command.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : assist_seq_if.slave (sensor inputs, dd_* operands and
//                dd_target_curr result, target_curr/curr_vld, busy, ovr_cnt)
// Optional feature macro: SLEW_LIMIT_EN -- rate-limit target_curr changes
// to SLEW_STEP per update via curr_slew; otherwise target_curr takes the
// captured datapath result directly.
module assist_seq
    import assist_seq_pkg::*;
#(
    parameter int          DD_LAT    = DD_LAT_DEF,
    parameter logic [11:0] SLEW_STEP = SLEW_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    assist_seq_if.slave bus
);
    localparam int            CW       = (DD_LAT < 1) ? 1 : $clog2(DD_LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DD_LAT);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          pend;
    logic [7:0]    ovr;
    logic          load_dd, do_cap, do_upd, busy, drop;

    logic [11:0]   dd_at_q;
    logic [4:0]    dd_cad_q;
    logic [12:0]   dd_inc_q;
    logic [2:0]    dd_sc_q;
    logic          dd_np_q;
    logic [11:0]   cap_q, tgt_q, curr_next;
    logic          vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_dd   = 1'b0;
        do_cap    = 1'b0;
        do_upd    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sample_rdy || pend) begin
                    load_dd   = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    do_cap    = 1'b1;
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                do_upd = 1'b1;
                if (pend) begin
                    load_dd   = 1'b1;
                    state_nxt = WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    // A reload consumes the pending slot, so a sample arriving with it is
    // re-queued rather than dropped.
    assign drop = bus.sample_rdy && busy && pend && !load_dd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= 1'b0;
            ovr  <= '0;
        end else begin
            if (load_dd) begin
                cnt  <= '0;
                // pend is only ever 1 here if a sample coincides with the reload
                pend <= pend & bus.sample_rdy;
            end else begin
                if (state == WAIT && cnt != CNT_LAST) cnt <= cnt + 1'b1;
                if (bus.sample_rdy && busy)           pend <= 1'b1;
            end
            if (drop && ovr != 8'hFF) ovr <= ovr + 1'b1;
        end
    end

    // Operands stay frozen from WAIT entry until the next reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dd_at_q  <= '0;
            dd_cad_q <= '0;
            dd_inc_q <= '0;
            dd_sc_q  <= '0;
            dd_np_q  <= 1'b0;
        end else if (load_dd) begin
            dd_at_q  <= bus.avg_torque;
            dd_cad_q <= bus.cadence;
            dd_inc_q <= bus.incline;
            dd_sc_q  <= bus.scale;
            dd_np_q  <= bus.not_pedaling;
        end
    end

`ifdef SLEW_LIMIT_EN
    curr_slew #(.STEP(SLEW_STEP)) u_slew (
        .cur (tgt_q),
        .tgt (cap_q),
        .nxt (curr_next)
    );
`else
    logic [11:0] unused_slew_step;
    assign unused_slew_step = SLEW_STEP;
    assign curr_next        = cap_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            tgt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            if (do_cap) cap_q <= bus.dd_target_curr;
            // not pedaling cuts assist immediately, bypassing any slew
            if (do_upd) tgt_q <= dd_np_q ? 12'h000 : curr_next;
            vld_q <= do_upd;
        end
    end

    assign bus.dd_avg_torque   = dd_at_q;
    assign bus.dd_cadence      = dd_cad_q;
    assign bus.dd_incline      = dd_inc_q;
    assign bus.dd_scale        = dd_sc_q;
    assign bus.dd_not_pedaling = dd_np_q;
    assign bus.target_curr     = tgt_q;
    assign bus.curr_vld        = vld_q;
    assign bus.busy            = busy;
    assign bus.ovr_cnt         = ovr;
endmodule

// File: tb/tb_assist_seq.sv
// tb_assist_seq -- randomized + directed bench for assist_seq with a
// transaction-level reference model and a scoreboard-driven monitor.
// Build with +define+SLEW_LIMIT_EN to exercise the slew-limited variant.
module tb_assist_seq;
    localparam int DD_LAT = 3;
    localparam int LAT    = DD_LAT + 2;   // start edge -> curr_vld edge
    localparam int STEP   = 'h40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    assist_seq_if bus();

    assist_seq #(.DD_LAT(DD_LAT), .SLEW_STEP(12'h040)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int mode = 0;

    // datapath stub: 0 -> constant 123, 1 -> constant 100, else operand hash
    function automatic logic [11:0] stub(int md, logic [11:0] at, logic [4:0] cad,
                                         logic [12:0] inc, logic [2:0] sc);
        case (md)
            0:       return 12'h123;
            1:       return 12'h100;
            default: return (at ^ {inc[6:0], cad}) + {7'd0, sc, 2'b01};
        endcase
    endfunction

    assign bus.dd_target_curr = stub(mode, bus.dd_avg_torque, bus.dd_cadence,
                                     bus.dd_incline, bus.dd_scale);

    int vecs = 0, errs = 0, n_vld = 0, cyc = 0;

    task automatic check(string nm, int got, int exp);
        vecs++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [11:0] val;
    } exp_t;
    exp_t        sb[$];

    bit          m_busy, m_pend, m_np;
    int          m_s;
    logic [11:0] m_f, m_cur;
    logic [7:0]  m_ovr;

    function automatic logic [11:0] next_val(logic [11:0] cur, logic [11:0] tgt);
`ifdef SLEW_LIMIT_EN
        int d;
        d = int'(tgt) - int'(cur);
        if (d > STEP)  return cur + 12'(STEP);
        if (d < -STEP) return cur - 12'(STEP);
        return tgt;
`else
        return tgt + 12'(cur) - cur;
`endif
    endfunction

    task automatic job_start();
        m_busy = 1'b1;
        m_s    = cyc;
        m_f    = stub(mode, bus.avg_torque, bus.cadence, bus.incline, bus.scale);
        m_np   = bus.not_pedaling;
    endtask

    // A job started at edge s occupies edges s+1..s+LAT and reports at s+LAT;
    // one sample can wait behind it, further ones are counted as dropped.
    task automatic model_step();
        bit smp;
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; m_cur = '0; m_ovr = '0;
            sb.delete();
            return;
        end
        cyc++;
        smp = bus.sample_rdy;
        if (m_busy && cyc == m_s + LAT) begin
            m_cur = m_np ? 12'h000 : next_val(m_cur, m_f);
            sb.push_back('{cyc, m_cur});
            if (m_pend) job_start();
            else        m_busy = 0;
            m_pend = smp;
        end else if (m_busy) begin
            if (smp) begin
                if (m_pend) m_ovr = (m_ovr == 8'hFF) ? 8'hFF : m_ovr + 8'd1;
                else        m_pend = 1;
            end
        end else if (smp || m_pend) begin
            job_start();
            m_pend = m_pend && smp;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // ---------------- monitor ----------------
    bit prev_vld = 0;

    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            prev_vld = 0;
            return;
        end
        check("busy", bus.busy, m_busy);
        check("ovr_cnt", bus.ovr_cnt, m_ovr);
        if (bus.curr_vld) begin
            n_vld++;
            check("curr_vld_back_to_back", prev_vld, 0);
            if (sb.size() == 0) begin
                check("curr_vld_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("curr_vld_cycle", cyc, e.due);
                check("target_curr", bus.target_curr, e.val);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("curr_vld_missing", 0, 1);
        end
        prev_vld = bus.curr_vld;
    endtask

    always @(negedge clk) monitor();

    // ---------------- stimulus ----------------
    task automatic set_rand(bit s, bit np);
        bus.sample_rdy   = s;
        bus.avg_torque   = 12'($urandom);
        bus.cadence      = 5'($urandom);
        bus.incline      = 13'($urandom);
        bus.scale        = 3'($urandom);
        bus.not_pedaling = np;
    endtask

    task automatic drive(bit s, bit np);
        @(negedge clk);
        set_rand(s, np);
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.sample_rdy = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    int base;
`ifdef SLEW_LIMIT_EN
    logic [11:0] slew_exp [5];
`endif

    initial begin
        set_rand(0, 0);
        repeat (2) @(negedge clk);
        check("rst_target_curr", bus.target_curr, 0);
        check("rst_curr_vld", bus.curr_vld, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovr_cnt", bus.ovr_cnt, 0);
        check("rst_dd_ops", {bus.dd_avg_torque, bus.dd_cadence, bus.dd_incline,
                             bus.dd_scale, bus.dd_not_pedaling}, 0);
        rst_n = 1;

        // nominal sample: operands held through WAIT and UPDATE
        mode = 0;
        @(negedge clk);
        set_rand(1, 0);
        bus.avg_torque = 12'h480; bus.cadence = 5'd16; bus.scale = 3'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("dd_avg_torque_hold", bus.dd_avg_torque, 12'h480);
            check("dd_cadence_hold", bus.dd_cadence, 16);
            check("dd_scale_hold", bus.dd_scale, 3);
            set_rand(0, 0);
        end
        idle(6);
        check("nominal_target_curr", bus.target_curr, 12'h123);

        // reset at WAIT count 2 aborts the job
        drive(1, 0); drive(0, 0); drive(0, 0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("abort_target_curr", bus.target_curr, 0);
        check("abort_curr_vld", bus.curr_vld, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_dd_avg_torque", bus.dd_avg_torque, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        drive(1, 0);
        idle(10);

        // three samples during one WAIT: one pend run, two drops
        mode = 2;
        base = n_vld;
        drive(1, 0); drive(1, 0); drive(1, 0); drive(1, 0);
        idle(15);
        check("pend_ovr_cnt", bus.ovr_cnt, 2);
        check("pend_pulse_count", n_vld - base, 2);

`ifdef SLEW_LIMIT_EN
        do_reset();
        mode = 1;
        slew_exp = '{12'h040, 12'h080, 12'h0C0, 12'h100, 12'h100};
        for (int i = 0; i < 5; i++) begin
            drive(1, 0);
            idle(8);
            check("slew_step", bus.target_curr, slew_exp[i]);
        end
`else
        mode = 1;
        drive(1, 0);
        idle(8);
        check("direct_target_curr", bus.target_curr, 12'h100);
`endif
        drive(1, 1);
        idle(8);
        check("not_pedaling_zero", bus.target_curr, 0);

        // continuous samples: drop counter saturates
        do_reset();
        mode = 2;
        for (int i = 0; i < 400; i++) drive(1, 1'($urandom));
        idle(12);
        check("ovr_saturate", bus.ovr_cnt, 8'hFF);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) drive(($urandom % 4) == 0, ($urandom % 8) == 0);
        for (int i = 0; i < 40 && (sb.size() != 0 || bus.busy); i++) drive(0, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/assist_seq.md
ASSIST_SEQ -- requirements
Module: assist_seq

Interface
REQ-001 Parameter DD_LAT, default 3, desired-drive pipeline depth in clocks.
REQ-002 Parameter SLEW_STEP, default 12'h040, maximum target_curr change per update.
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 sample_rdy  in  1  one-cycle pulse: new sensor sample available.
REQ-006 avg_torque  in  12, cadence  in  5, incline  in  13, scale  in  3, not_pedaling  in  1: raw sensor and config inputs.
REQ-007 dd_avg_torque  out  12, dd_cadence  out  5, dd_incline  out  13, dd_scale  out  3, dd_not_pedaling  out  1: held operands to the desired-drive datapath.
REQ-008 dd_target_curr  in  12  datapath result.
REQ-009 target_curr  out  12  sequenced motor current command.
REQ-010 curr_vld  out  1  one-cycle pulse: target_curr updated.
REQ-011 busy  out  1  high whenever state is not IDLE.
REQ-012 ovr_cnt  out  8  saturating count of dropped samples.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, UPDATE.
REQ-014 IDLE with sample_rdy (or pend set): load all dd_* registers from current inputs, clear wait counter, clear pend, go WAIT.
REQ-015 dd_* SHALL hold constant from WAIT entry until the next IDLE->WAIT transition.
REQ-016 WAIT: count 0..DD_LAT; at count==DD_LAT capture dd_target_curr into cap register, go UPDATE.
REQ-017 UPDATE: write target_curr per REQ-022/REQ-023, pulse curr_vld for one cycle, go IDLE; go directly WAIT (reloading dd_*) if pend set.
REQ-018 Latency: curr_vld SHALL be high in the cycle after the 6th rising edge counting the edge that samples sample_rdy as 1st (DD_LAT=3).
REQ-019 sample_rdy while busy SHALL set pend (one-deep); if pend already set, ovr_cnt increments, saturating at 8'hFF.
REQ-020 sample_rdy in the same cycle as UPDATE->WAIT via pend: pend re-sets; no drop counted.
REQ-021 curr_vld SHALL never be high on two consecutive cycles.
REQ-022 Without SLEW_LIMIT_EN: target_curr <= cap.
REQ-023 dd_not_pedaling==1 at UPDATE: target_curr <= 0 regardless of configuration.

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE, pend 0, wait counter 0, all dd_* 0, target_curr 0, curr_vld 0, ovr_cnt 0.
REQ-025 Reset mid-WAIT/UPDATE SHALL abort the computation with no curr_vld pulse; first sample after release runs normally.

Configuration
REQ-026 Macro SLEW_LIMIT_EN defined: at UPDATE target_curr moves toward cap by min(|cap-target_curr|, SLEW_STEP), unsigned, no overshoot, no wrap below 0 or above 12'hFFF.
REQ-027 SLEW_LIMIT_EN undefined: no slew logic compiled; REQ-022 applies.

Structure
REQ-028 Shared package SHALL hold state enum (IDLE/WAIT/UPDATE), TORQUE_MIN, default DD_LAT and SLEW_STEP constants.
REQ-029 Slew stepping SHALL be one sub-module, curr_slew, instantiated only under SLEW_LIMIT_EN.

Verification
REQ-030 Datapath stub returns 12'h123 (slew off): sample_rdy, avg_torque=12'h480, cadence=16, scale=3 -> dd_* stable 5 cycles, target_curr=12'h123, curr_vld on 6th edge.
REQ-031 Slew on, target_curr=0, stub 12'h100 -> four consecutive samples give 12'h040, 12'h080, 12'h0C0, 12'h100; fifth stays 12'h100.
REQ-032 Slew on, target_curr=12'h100, not_pedaling=1 -> next curr_vld with target_curr=12'h000.
REQ-033 Three sample_rdy pulses during one WAIT -> one pend run after UPDATE, ovr_cnt=2, exactly two curr_vld pulses total.
REQ-034 rst_n low at WAIT count 2 -> all outputs 0 immediately, no curr_vld; next sample completes with 6-edge latency.
REQ-035 300 dropped samples -> ovr_cnt holds 8'hFF.
